v_serial_tx: RTL and testbench



---
 rtl/v_serial_tx.sv | 164 ++++++++++++++++
 tb/tb_v_serial_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/v_serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, optional even parity, stop bit; line idles high.
// Latency: accepted LOAD drives SO low on the next clock; a frame keeps RDY low for (WIDTH+2)*DIV cycles, (WIDTH+3)*DIV with parity.
// Backpressure: RDY=1 only in IDLE; LOAD while busy is ignored. Optional parity bit enabled by macro SERIAL_TX_PARITY_EN.
module v_serial_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             RDY,
  output logic             SO,
  output logic             BUSY
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_tmr, w_tmr_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_so, w_so_nxt;
  logic             w_bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_bit_end = (r_tmr == TMAX);

  // Next-state, timer/index/shift updates, and the value SO takes after the edge.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_so_nxt    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_tmr_nxt = '0;
        w_idx_nxt = '0;
        if (LOAD) begin
          w_shreg_nxt = D;
`ifdef SERIAL_TX_PARITY_EN
          w_par_nxt   = ^D;
`endif
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_tmr_nxt   = '0;
          w_shreg_nxt = r_shreg >> 1;
          if (r_idx == IMAX) begin
            w_idx_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      default: begin
        // Unreachable encoding: recover to idle with the line high.
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = '0;
        w_idx_nxt   = '0;
        w_shreg_nxt = '0;
      end
    endcase

    // SO is registered, so decode it from the post-edge state and shift value.
    case (w_state_nxt)
      S_START:  w_so_nxt = 1'b0;
      S_DATA:   w_so_nxt = w_shreg_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: w_so_nxt = w_par_nxt;
`endif
      default:  w_so_nxt = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_so    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      r_so    <= w_so_nxt;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign RDY  = (r_state == S_IDLE);
  assign BUSY = ~RDY;
  assign SO   = r_so;

endmodule

// File: tb/tb_v_serial_tx.sv
// Bench for v_serial_tx: three instances (DIV=4, DIV=1, DIV=2, WIDTH=4) against a frame-level model.
// The model builds each frame as a list of bit values and indexes it by elapsed cycles.
// Directed scenarios add literal expectations on bit sequences and RDY timing.
module tb_v_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] load_s = '0;
  logic [3:0] d_s [3];
  logic [2:0] rdy_s, so_s, busy_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  v_serial_tx #(.WIDTH(4), .DIV(4)) u_a (.C(clk), .CLR(clr), .D(d_s[0]), .LOAD(load_s[0]),
                                          .RDY(rdy_s[0]), .SO(so_s[0]), .BUSY(busy_s[0]));
  v_serial_tx #(.WIDTH(4), .DIV(1)) u_b (.C(clk), .CLR(clr), .D(d_s[1]), .LOAD(load_s[1]),
                                          .RDY(rdy_s[1]), .SO(so_s[1]), .BUSY(busy_s[1]));
  v_serial_tx #(.WIDTH(4), .DIV(2)) u_c (.C(clk), .CLR(clr), .D(d_s[2]), .LOAD(load_s[2]),
                                          .RDY(rdy_s[2]), .SO(so_s[2]), .BUSY(busy_s[2]));

  function automatic int div_of(input int k);
    case (k)
      0: return 4;
      1: return 1;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: remaining busy cycles, position in frame, and the frame's bit list.
  int         m_cnt [3];
  int         m_pos [3];
  logic [7:0] m_bits [3];
  bit         m_init = 1'b0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k] = 0;
        m_pos[k] = 0;
      end
      m_init = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_cnt[k] == 0) begin
          if (load_s[k]) begin
            m_bits[k]    = 8'hFF;
            m_bits[k][0] = 1'b0;
            for (int i = 0; i < 4; i++) m_bits[k][1+i] = d_s[k][i];
`ifdef SERIAL_TX_PARITY_EN
            m_bits[k][5] = ^d_s[k];
`endif
            m_cnt[k] = NB * div_of(k);
            m_pos[k] = 0;
          end
        end else begin
          m_cnt[k]--;
          m_pos[k]++;
        end
      end
    end
  end

  // Every cycle, compare all three instances against the model.
  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 3; k++) begin
        logic e_so;
        e_so = (m_cnt[k] == 0) ? 1'b1 : m_bits[k][m_pos[k] / div_of(k)];
        chk($sformatf("so[%0d]", k), so_s[k], e_so);
        chk($sformatf("rdy[%0d]", k), rdy_s[k], (m_cnt[k] == 0) ? 1 : 0);
        chk($sformatf("busy[%0d]", k), busy_s[k], (m_cnt[k] == 0) ? 0 : 1);
      end
    end
  end

  // One frame on instance s; optionally throws ignored LOADs into the middle of it.
  task automatic run_frame(input int s, input logic [3:0] d, input logic [7:0] exp,
                           input bit inject, input string nm);
    int         div;
    int         low;
    logic [7:0] got;
    div = div_of(s);
    low = 0;
    got = '0;
    @(posedge clk); #2;
    load_s[s] = 1'b1;
    d_s[s]    = d;
    @(posedge clk); #2;
    load_s[s] = 1'b0;
    for (int k = 0; k < NB * div + 6; k++) begin
      @(negedge clk);
      if (k == 0) chk({nm, "_fall_latency"}, so_s[s], 0);
      if (rdy_s[s] == 1'b0) low++;
      if ((k / div) < NB && (k % div) == (div / 2)) got[k / div] = so_s[s];
      if (inject && (k == 5 || k == 20)) begin
        load_s[s] = 1'b1;
        d_s[s]    = 4'b0101;
      end
      if (inject && (k == 6 || k == 21)) load_s[s] = 1'b0;
    end
    chk({nm, "_bits"}, got, exp);
    chk({nm, "_rdy_low"}, low, NB * div);
  endtask

  initial begin
    logic [15:0] got_b;
    logic [15:0] exp_b;
    int          rdy_hi;
    for (int k = 0; k < 3; k++) d_s[k] = 4'b0000;

    // Asynchronous reset mid-cycle, then held across edges with LOAD high.
    #3 clr = 1'b1;
    #1;
    chk("clr_async_so", so_s[0], 1);
    chk("clr_async_rdy", rdy_s[0], 1);
    chk("clr_async_busy", busy_s[0], 0);
    load_s = 3'b111;
    repeat (3) @(posedge clk);
    #2;
    clr    = 1'b0;
    load_s = 3'b000;
    repeat (2) @(negedge clk);
    chk("no_frame_after_clr", rdy_s[0], 1);

    // Basic frame, then the same frame with LOADs injected while busy.
`ifdef SERIAL_TX_PARITY_EN
    run_frame(0, 4'b1010, 8'b0101_0100, 1'b0, "a1010");
    run_frame(0, 4'b1010, 8'b0101_0100, 1'b1, "a1010_inj");
`else
    run_frame(0, 4'b1010, 8'b0011_0100, 1'b0, "a1010");
    run_frame(0, 4'b1010, 8'b0011_0100, 1'b1, "a1010_inj");
`endif

    // Reset ten cycles into a frame, then a clean frame.
    @(posedge clk); #2;
    load_s[0] = 1'b1;
    d_s[0]    = 4'b1111;
    @(posedge clk); #2;
    load_s[0] = 1'b0;
    repeat (10) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("midframe_clr_so", so_s[0], 1);
    chk("midframe_clr_rdy", rdy_s[0], 1);
    chk("midframe_clr_busy", busy_s[0], 0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    run_frame(0, 4'b0001, 8'b0110_0010, 1'b0, "a0001");
`else
    run_frame(0, 4'b0001, 8'b0010_0010, 1'b0, "a0001");
`endif

    // DIV=1, LOAD held high across two back-to-back frames.
    got_b  = '0;
    rdy_hi = 0;
`ifdef SERIAL_TX_PARITY_EN
    exp_b = 16'b1101_1000_1100_0110;
`else
    exp_b = 16'b0011_1100_0110_0110;
`endif
    @(posedge clk); #2;
    load_s[1] = 1'b1;
    d_s[1]    = 4'b0011;
    @(posedge clk);
    for (int k = 0; k < 2 * NB + 2; k++) begin
      @(negedge clk);
      got_b[k] = so_s[1];
      if (k < 2 * NB + 1 && rdy_s[1]) rdy_hi++;
      if (k == 0) d_s[1] = 4'b1100;
      if (k == NB + 1) load_s[1] = 1'b0;
    end
    chk("b_backtoback_seq", got_b, exp_b);
    chk("b_rdy_gap", rdy_hi, 1);

    // DIV=2 frames covering both parity values.
`ifdef SERIAL_TX_PARITY_EN
    run_frame(2, 4'b0111, 8'b0110_1110, 1'b0, "c0111");
    run_frame(2, 4'b0011, 8'b0100_0110, 1'b0, "c0011");
`else
    run_frame(2, 4'b0111, 8'b0010_1110, 1'b0, "c0111");
    run_frame(2, 4'b0011, 8'b0010_0110, 1'b0, "c0011");
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
